// File: rtl/router_pkg.sv
// Shared types and limits for the N-port router control FSM.
package router_pkg;

  localparam int ROUTER_MAX_PORTS = 8;
  localparam int IDX_W            = $clog2(ROUTER_MAX_PORTS);

  typedef enum logic [3:0] {
    ST_DECODE       = 4'd0,
    ST_LFD          = 4'd1,
    ST_LOAD_DATA    = 4'd2,
    ST_LOAD_PARITY  = 4'd3,
    ST_CHECK_PARITY = 4'd4,
    ST_FIFO_FULL    = 4'd5,
    ST_LAF          = 4'd6,
    ST_WAIT_EMPTY   = 4'd7,
    ST_DROP         = 4'd8
  } router_state_e;

endpackage

// File: rtl/router_wait_timer.sv
// WAIT_EMPTY timeout timer: reloads on clear, counts down while enabled,
// flags expiry at terminal count. Only used when ROUTER_FSM_TIMEOUT_EN is defined.
module router_wait_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clockf,
  input  logic resetf,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LOAD_VAL = 16'(TIMEOUT_CYC - 1);

  logic [15:0] count;

  always_ff @(posedge clockf or posedge resetf) begin
    if (resetf) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD_VAL;
    end else if (enable && (count != '0)) begin
      count <= count - 16'd1;
    end
  end

  assign expired = enable && (count == '0);

endmodule

// File: rtl/router_fsm_nport.sv
// N-port router control FSM with Moore-decoded register-block/FIFO controls.
// Optional WAIT_EMPTY timeout-to-drop is enabled by defining ROUTER_FSM_TIMEOUT_EN.
//
// state           | meaning
// DECODE          | idle, waiting for a header; latches port_sel
// LFD             | load first (header) byte
// LOAD_DATA       | stream payload into selected FIFO
// LOAD_PARITY     | load trailing parity byte
// CHECK_PARITY    | parity compare in register block
// FIFO_FULL       | selected FIFO full, stalled
// LAF             | load after full, resume where the stall hit
// WAIT_EMPTY      | header seen but selected FIFO not yet empty
// DROP            | invalid destination, discard until pkt_valid falls
module router_fsm_nport
  import router_pkg::*;
#(
  parameter int  NUM_PORTS   = 3,
  parameter int  TIMEOUT_CYC = 64,
  localparam int ADDR_W      = $clog2(NUM_PORTS)
) (
  input  logic                 clockf,
  input  logic                 resetf,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic                 drop_pkt,
  output logic [ADDR_W-1:0]    port_sel,
  output logic                 timeout
);

  if (NUM_PORTS < 2 || NUM_PORTS > ROUTER_MAX_PORTS ||
      TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_param_check
    $error("router_fsm_nport: NUM_PORTS or TIMEOUT_CYC out of range");
  end

  router_state_e state, state_nxt;

  logic [ROUTER_MAX_PORTS-1:0] full_ext, empty_ext, soft_ext;
  logic [IDX_W-1:0]            sel_idx, din_idx;
  logic                        din_oob;
  logic                        tmr_expired;

  // Widen per-port flags so an out-of-range index reads 0 instead of X.
  assign full_ext  = ROUTER_MAX_PORTS'(fifo_full);
  assign empty_ext = ROUTER_MAX_PORTS'(fifo_empty);
  assign soft_ext  = ROUTER_MAX_PORTS'(soft_reset);
  assign sel_idx   = IDX_W'(port_sel);
  assign din_idx   = IDX_W'(data_in);
  assign din_oob   = int'(data_in) >= NUM_PORTS;

`ifdef ROUTER_FSM_TIMEOUT_EN
  router_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_timer (
    .clockf (clockf),
    .resetf (resetf),
    .clear  (state != ST_WAIT_EMPTY),
    .enable (state == ST_WAIT_EMPTY),
    .expired(tmr_expired)
  );

  // Only an expiry can take WAIT_EMPTY to DROP, so this marks the first DROP cycle.
  always_ff @(posedge clockf or posedge resetf) begin
    if (resetf) begin
      timeout <= 1'b0;
    end else begin
      timeout <= (state == ST_WAIT_EMPTY) && (state_nxt == ST_DROP);
    end
  end
`else
  assign tmr_expired = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clockf or posedge resetf) begin
    if (resetf) begin
      state    <= ST_DECODE;
      port_sel <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE && pkt_valid) begin
        port_sel <= data_in;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_DECODE: begin
        if (pkt_valid) begin
          if (din_oob)                 state_nxt = ST_DROP;
          else if (empty_ext[din_idx]) state_nxt = ST_LFD;
          else                         state_nxt = ST_WAIT_EMPTY;
        end
      end
      ST_LFD:          state_nxt = ST_LOAD_DATA;
      ST_LOAD_DATA: begin
        if (full_ext[sel_idx]) state_nxt = ST_FIFO_FULL;
        else if (!pkt_valid)   state_nxt = ST_LOAD_PARITY;
      end
      ST_LOAD_PARITY:  state_nxt = ST_CHECK_PARITY;
      ST_CHECK_PARITY: state_nxt = full_ext[sel_idx] ? ST_FIFO_FULL : ST_DECODE;
      ST_FIFO_FULL: begin
        if (!full_ext[sel_idx]) state_nxt = ST_LAF;
      end
      ST_LAF: begin
        if (parity_done)        state_nxt = ST_DECODE;
        else if (low_pkt_valid) state_nxt = ST_LOAD_PARITY;
        else                    state_nxt = ST_LOAD_DATA;
      end
      ST_WAIT_EMPTY: begin
        if (empty_ext[sel_idx]) state_nxt = ST_LFD;
        else if (tmr_expired)   state_nxt = ST_DROP;
      end
      ST_DROP: begin
        if (!pkt_valid) state_nxt = ST_DECODE;
      end
      default:         state_nxt = ST_DECODE;
    endcase

    if (soft_ext[sel_idx] && state != ST_DECODE && state != ST_DROP) begin
      state_nxt = ST_DECODE;
    end
  end

  assign detect_add    = (state == ST_DECODE);
  assign lfd_state     = (state == ST_LFD);
  assign ld_state      = (state == ST_LOAD_DATA);
  assign laf_state     = (state == ST_LAF);
  assign full_state    = (state == ST_FIFO_FULL);
  assign rst_int_reg   = (state == ST_CHECK_PARITY);
  assign drop_pkt      = (state == ST_DROP);
  assign write_enb_reg = (state inside {ST_LOAD_DATA, ST_LOAD_PARITY, ST_LAF});
  assign busy          = !(state inside {ST_DECODE, ST_LOAD_DATA, ST_DROP});

endmodule

// File: tb/tb_router_fsm_nport.sv
// Bench for router_fsm_nport: 4-port and 3-port instances on shared stimulus,
// checked every cycle against a rule-level model plus literal spot checks.
module tb_router_fsm_nport;

  localparam int TO_CYC = 8;
`ifdef ROUTER_FSM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Output vector order: detect_add lfd ld laf full rst_int web busy drop timeout
  localparam logic [9:0] L_DEC  = 10'b1000000000;
  localparam logic [9:0] L_LFD  = 10'b0100000100;
  localparam logic [9:0] L_LOAD = 10'b0010001000;
  localparam logic [9:0] L_LP   = 10'b0000001100;
  localparam logic [9:0] L_CP   = 10'b0000010100;
  localparam logic [9:0] L_FULL = 10'b0000100100;
  localparam logic [9:0] L_LAF  = 10'b0001001100;
  localparam logic [9:0] L_WAIT = 10'b0000000100;
  localparam logic [9:0] L_DROP = 10'b0000000010;
  localparam logic [9:0] L_DRTO = 10'b0000000011;

  // Model phases (bench-local numbering).
  localparam int S_IDLE = 10, S_HDR = 11, S_BODY = 12, S_PAR = 13, S_CHK = 14;
  localparam int S_STALL = 15, S_RESUME = 16, S_WAIT = 17, S_DISC = 18;

  logic       clockf = 1'b0;
  logic       resetf;
  logic       pkt_valid, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic [3:0] fifo_full, fifo_empty, soft_reset;
  wire  [9:0] o4, o3;
  wire  [1:0] ps4, ps3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clockf = ~clockf;

  router_fsm_nport #(.NUM_PORTS(4), .TIMEOUT_CYC(TO_CYC)) u_dut4 (
    .clockf(clockf), .resetf(resetf), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(o4[9]), .lfd_state(o4[8]), .ld_state(o4[7]), .laf_state(o4[6]),
    .full_state(o4[5]), .rst_int_reg(o4[4]), .write_enb_reg(o4[3]), .busy(o4[2]),
    .drop_pkt(o4[1]), .port_sel(ps4), .timeout(o4[0])
  );

  router_fsm_nport #(.NUM_PORTS(3), .TIMEOUT_CYC(TO_CYC)) u_dut3 (
    .clockf(clockf), .resetf(resetf), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full[2:0]), .fifo_empty(fifo_empty[2:0]), .soft_reset(soft_reset[2:0]),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(o3[9]), .lfd_state(o3[8]), .ld_state(o3[7]), .laf_state(o3[6]),
    .full_state(o3[5]), .rst_int_reg(o3[4]), .write_enb_reg(o3[3]), .busy(o3[2]),
    .drop_pkt(o3[1]), .port_sel(ps3), .timeout(o3[0])
  );

  int         np_of[2] = '{4, 3};
  int         m_st[2];
  logic [1:0] m_ps[2];
  int         m_wc[2];
  bit         m_to[2];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] exp_outs(int st, bit to);
    logic [9:0] v;
    v    = '0;
    v[9] = (st == S_IDLE);
    v[8] = (st == S_HDR);
    v[7] = (st == S_BODY);
    v[6] = (st == S_RESUME);
    v[5] = (st == S_STALL);
    v[4] = (st == S_CHK);
    v[3] = (st == S_BODY) || (st == S_PAR) || (st == S_RESUME);
    v[2] = !((st == S_IDLE) || (st == S_BODY) || (st == S_DISC));
    v[1] = (st == S_DISC);
    v[0] = to;
    return v;
  endfunction

  function automatic void model_step(int k);
    int np, st, ps, din, nxt;
    bit sel_full, sel_empty, sel_soft, to;
    np        = np_of[k];
    st        = m_st[k];
    ps        = int'(m_ps[k]);
    din       = int'(data_in);
    sel_full  = (ps < np) && fifo_full[ps];
    sel_empty = (ps < np) && fifo_empty[ps];
    sel_soft  = (ps < np) && soft_reset[ps];
    nxt       = st;
    to        = 1'b0;
    case (st)
      S_IDLE: if (pkt_valid) begin
        m_ps[k] = data_in;
        if (din >= np)            nxt = S_DISC;
        else if (fifo_empty[din]) nxt = S_HDR;
        else begin nxt = S_WAIT; m_wc[k] = 0; end
      end
      S_HDR:    nxt = S_BODY;
      S_BODY:   nxt = sel_full ? S_STALL : (!pkt_valid ? S_PAR : S_BODY);
      S_PAR:    nxt = S_CHK;
      S_CHK:    nxt = sel_full ? S_STALL : S_IDLE;
      S_STALL:  nxt = sel_full ? S_STALL : S_RESUME;
      S_RESUME: nxt = parity_done ? S_IDLE : (low_pkt_valid ? S_PAR : S_BODY);
      S_WAIT: begin
        m_wc[k] = m_wc[k] + 1;
        if (sel_empty) nxt = S_HDR;
        else if (TO_EN && m_wc[k] >= TO_CYC) begin nxt = S_DISC; to = 1'b1; end
      end
      S_DISC:   nxt = pkt_valid ? S_DISC : S_IDLE;
      default:  nxt = S_IDLE;
    endcase
    if (sel_soft && st != S_IDLE && st != S_DISC) begin
      nxt = S_IDLE;
      to  = 1'b0;
    end
    m_st[k] = nxt;
    m_to[k] = to;
  endfunction

  always @(posedge clockf or posedge resetf) begin
    for (int k = 0; k < 2; k++) begin
      if (resetf) begin
        m_st[k] = S_IDLE;
        m_ps[k] = 2'd0;
        m_wc[k] = 0;
        m_to[k] = 1'b0;
      end else begin
        model_step(k);
      end
    end
  end

  always @(negedge clockf) begin
    chk("model_p4", {20'd0, o4, ps4}, {20'd0, exp_outs(m_st[0], m_to[0]), m_ps[0]});
    chk("model_p3", {20'd0, o3, ps3}, {20'd0, exp_outs(m_st[1], m_to[1]), m_ps[1]});
  end

  task automatic tick();
    @(posedge clockf);
    #1;
  endtask

  initial begin
    resetf = 1'b1;
    pkt_valid = 1'b0; data_in = 2'd0; parity_done = 1'b0; low_pkt_valid = 1'b0;
    fifo_full = 4'b0000; fifo_empty = 4'b1111; soft_reset = 4'b0000;
    tick(); tick();
    chk("reset_p4", {o4, ps4}, {L_DEC, 2'd0});
    chk("reset_p3", {o3, ps3}, {L_DEC, 2'd0});
    resetf = 1'b0;
    tick();

    // Normal packet to port 2.
    pkt_valid = 1'b1; data_in = 2'd2;
    tick(); chk("pkt_lfd", {o4, ps4}, {L_LFD, 2'd2});
    tick(); chk("pkt_load", o4, L_LOAD);
    tick(); chk("pkt_load_hold", o4, L_LOAD);
    pkt_valid = 1'b0;
    tick(); chk("pkt_parity", o4, L_LP);
    tick(); chk("pkt_check", o4, L_CP);
    tick(); chk("pkt_done", {o4, ps4}, {L_DEC, 2'd2});

    // Full stall on port 1, resume into parity.
    pkt_valid = 1'b1; data_in = 2'd1;
    tick(); tick();
    fifo_full = 4'b0010;
    tick(); chk("full_stall", o4, L_FULL);
    tick(); chk("full_hold", o4, L_FULL);
    fifo_full = 4'b0000; low_pkt_valid = 1'b1;
    tick(); chk("laf", o4, L_LAF);
    tick(); chk("laf_to_parity", o4, L_LP);
    pkt_valid = 1'b0; low_pkt_valid = 1'b0;
    tick(); tick(); chk("full_done", o4, L_DEC);

    // LAF with parity_done returns straight to DECODE.
    pkt_valid = 1'b1;
    tick(); tick();
    fifo_full = 4'b0010;
    tick();
    fifo_full = 4'b0000; parity_done = 1'b1; pkt_valid = 1'b0;
    tick(); chk("laf_pd", o4, L_LAF);
    tick(); chk("laf_pd_dec", o4, L_DEC);
    parity_done = 1'b0;

    // Out-of-range address on the 3-port instance.
    pkt_valid = 1'b1; data_in = 2'd3;
    tick(); chk("drop_p3", {o3, ps3}, {L_DROP, 2'd3});
    chk("oob_p4_lfd", o4, L_LFD);
    tick(); chk("drop_hold", o3, L_DROP);
    tick(); chk("drop_hold2", o3, L_DROP);
    pkt_valid = 1'b0;
    tick(); chk("drop_exit", o3, L_DEC);
    tick(); tick(); chk("oob_p4_done", o4, L_DEC);

    // Soft reset: non-selected ignored, selected aborts even over LOAD->PARITY.
    pkt_valid = 1'b1; data_in = 2'd2;
    tick(); tick();
    soft_reset = 4'b0001;
    tick(); chk("soft_other", o4, L_LOAD);
    soft_reset = 4'b0100; pkt_valid = 1'b0;
    tick(); chk("soft_sel", o4, L_DEC);
    chk("soft_sel_p3", o3, L_DEC);
    soft_reset = 4'b0000;
    tick();

    // Asynchronous reset in the middle of LAF.
    pkt_valid = 1'b1; data_in = 2'd1;
    tick(); tick();
    fifo_full = 4'b0010;
    tick();
    fifo_full = 4'b0000;
    tick(); chk("pre_async_laf", {o4, ps4}, {L_LAF, 2'd1});
    #2 resetf = 1'b1;
    #1 chk("async_rst_p4", {o4, ps4}, {L_DEC, 2'd0});
    chk("async_rst_p3", {o3, ps3}, {L_DEC, 2'd0});
    pkt_valid = 1'b0;
    tick();
    resetf = 1'b0;
    tick();

    // WAIT_EMPTY on port 0 that never drains.
    pkt_valid = 1'b1; data_in = 2'd0; fifo_empty = 4'b1110;
    tick(); chk("wait_enter", {o4, ps4}, {L_WAIT, 2'd0});
    repeat (TO_CYC - 1) tick();
    chk("wait_last", o4, L_WAIT);
    tick();
`ifdef ROUTER_FSM_TIMEOUT_EN
    chk("timeout_pulse", o4, L_DRTO);
    chk("timeout_pulse_p3", o3, L_DRTO);
    tick(); chk("timeout_single", o4, L_DROP);
    pkt_valid = 1'b0;
    tick(); chk("timeout_exit", o4, L_DEC);
`else
    chk("wait_forever", o4, L_WAIT);
    tick(); chk("wait_forever2", o4, L_WAIT);
    fifo_empty = 4'b1111;
    tick(); chk("wait_drain", o4, L_LFD);
    pkt_valid = 1'b0;
    tick(); tick(); tick(); tick(); chk("wait_drain_done", o4, L_DEC);
`endif

    // WAIT_EMPTY where the FIFO drains on the expiry cycle.
    pkt_valid = 1'b1; data_in = 2'd0; fifo_empty = 4'b1110;
    tick(); chk("wait2_enter", o4, L_WAIT);
    repeat (TO_CYC - 1) tick();
    fifo_empty = 4'b1111;
    tick(); chk("wait2_lfd", o4, L_LFD);
    chk("wait2_lfd_p3", o3, L_LFD);
    pkt_valid = 1'b0;
    tick(); chk("wait2_load", o4, L_LOAD);
    tick(); tick(); tick(); chk("wait2_done", o4, L_DEC);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
